// File: rtl/tb6612_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb6612_pwm_ctrl
//  Purpose  : Command-to-pin sequencer for a TB6612 dual H-bridge. Accepts
//             per-channel direction/duty commands over valid/ready, drives
//             glitch-free IN1/IN2/PWM per channel plus STBY, inserts a
//             short-brake dead-time on every direction reversal and drops
//             STBY after an idle timeout with both channels coasting.
//  Ports    :
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    enable     in   global enable; 0 forces everything off and STBY low
//    cmd_valid  in   command present
//    cmd_ready  out  command can be accepted (registered)
//    cmd_chan   in   0 = channel A, 1 = channel B
//    cmd_dir    in   00 coast, 01 forward, 10 reverse, 11 brake
//    cmd_duty   in   requested duty, all-ones = 100 %
//    AIN1/AIN2/PWMA, BIN1/BIN2/PWMB  out  driver inputs per channel
//    STBY       out  driver standby (1 = active)
//  Revision : 1.0  initial release
// ============================================================================
module tb6612_pwm_ctrl #(
  parameter int CNT_W        = 8,
  parameter int BRAKE_CYC    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chan,
  input  logic [1:0]       cmd_dir,
  input  logic [CNT_W-1:0] cmd_duty,
  output logic             AIN1,
  output logic             AIN2,
  output logic             PWMA,
  output logic             BIN1,
  output logic             BIN2,
  output logic             PWMB,
  output logic             STBY
);

  localparam int DT_W   = $clog2(BRAKE_CYC + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  // Counter runs 0..2^CNT_W-2 so an all-ones duty is strictly greater than
  // every count value and yields a constant-high PWM.
  localparam logic [CNT_W-1:0]  c_cnt_max  = CNT_W'((2 ** CNT_W) - 2);
  localparam logic [DT_W-1:0]   c_brake    = DT_W'(BRAKE_CYC);
  localparam logic [IDLE_W-1:0] c_idle_sat = IDLE_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_COAST    = 2'd0,
    ST_BRAKE    = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_BRAKE_DT = 2'd3
  } chan_st_e;

  // --------------------------------------------------------------------------
  // Registered state (index 0 = channel A, 1 = channel B)
  // --------------------------------------------------------------------------
  chan_st_e          r_st   [2];
  logic [1:0]        r_dir;          // 1 = reverse
  logic [CNT_W-1:0]  r_pend [2];
  logic [CNT_W-1:0]  r_act  [2];
  logic [DT_W-1:0]   r_dt   [2];
  logic [CNT_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_ready;
  logic [1:0]        r_in1;
  logic [1:0]        r_in2;
  logic [1:0]        r_pwm;
  logic              r_stby;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  chan_st_e          w_st_nxt   [2];
  logic [1:0]        w_dir_nxt;
  logic [CNT_W-1:0]  w_pend_nxt [2];
  logic [CNT_W-1:0]  w_act_nxt  [2];
  logic [DT_W-1:0]   w_dt_nxt   [2];
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic              w_wrap;
  logic              w_accept;
  logic [1:0]        w_hit;
  logic [1:0]        w_nc_cur;
  logic [1:0]        w_nc_nxt;
  logic [1:0]        w_in1_nxt;
  logic [1:0]        w_in2_nxt;
  logic [1:0]        w_pwm_nxt;
  logic              w_stby_nxt;
  logic              w_ready_nxt;

  // --------------------------------------------------------------------------
  // Channel FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        r_st[ch] <= ST_COAST;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_st[ch] <= w_st_nxt[ch];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, datapath and pin decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_st_nxt   = r_st;
    w_dir_nxt  = r_dir;
    w_pend_nxt = r_pend;
    w_act_nxt  = r_act;
    w_dt_nxt   = r_dt;
    w_hit      = '0;
    w_nc_cur   = '0;
    w_nc_nxt   = '0;
    w_in1_nxt  = '0;
    w_in2_nxt  = '0;
    w_pwm_nxt  = '0;

    w_wrap    = enable && (r_cnt == c_cnt_max);
    w_cnt_nxt = '0;
    if (enable && !w_wrap) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // Gating with enable covers the cycle enable drops while r_ready is
    // still high from the previous cycle.
    w_accept = cmd_valid && r_ready && enable;

    for (int ch = 0; ch < 2; ch++) begin
      w_hit[ch] = w_accept && (cmd_chan == ch[0]);

      if (!enable) begin
        w_st_nxt[ch]   = ST_COAST;
        w_pend_nxt[ch] = '0;
        w_act_nxt[ch]  = '0;
        w_dt_nxt[ch]   = '0;
      end else begin
        case (r_st[ch])
          ST_DRIVE: begin
            // Duty only changes at the period boundary: no truncated pulses.
            if (w_wrap) begin
              w_act_nxt[ch] = r_pend[ch];
            end
          end
          ST_BRAKE_DT: begin
            // Loaded with BRAKE_CYC on entry; leaving at 1 gives exactly
            // BRAKE_CYC cycles of IN=11 on the pins.
            if (r_dt[ch] == DT_W'(1)) begin
              w_st_nxt[ch]  = ST_DRIVE;
              w_act_nxt[ch] = '0;
              w_dt_nxt[ch]  = '0;
            end else begin
              w_dt_nxt[ch] = r_dt[ch] - DT_W'(1);
            end
          end
          default: ;
        endcase

        if (w_hit[ch]) begin
          case (cmd_dir)
            2'b00: begin
              w_st_nxt[ch]   = ST_COAST;
              w_act_nxt[ch]  = '0;
              w_pend_nxt[ch] = '0;
              w_dt_nxt[ch]   = '0;
            end
            2'b11: begin
              w_st_nxt[ch]   = ST_BRAKE;
              w_act_nxt[ch]  = '0;
              w_pend_nxt[ch] = '0;
              w_dt_nxt[ch]   = '0;
            end
            default: begin
              if ((r_st[ch] == ST_DRIVE) && (cmd_dir[1] != r_dir[ch])) begin
                // Reversal: brake first, new direction/duty held meanwhile.
                w_st_nxt[ch]   = ST_BRAKE_DT;
                w_dt_nxt[ch]   = c_brake;
                w_dir_nxt[ch]  = cmd_dir[1];
                w_pend_nxt[ch] = cmd_duty;
                w_act_nxt[ch]  = '0;
              end else if (r_st[ch] == ST_DRIVE) begin
                w_pend_nxt[ch] = cmd_duty;
              end else begin
                w_st_nxt[ch]   = ST_DRIVE;
                w_dir_nxt[ch]  = cmd_dir[1];
                w_pend_nxt[ch] = cmd_duty;
                w_act_nxt[ch]  = '0;
              end
            end
          endcase
        end
      end

      w_nc_cur[ch] = (r_st[ch] != ST_COAST);
      w_nc_nxt[ch] = (w_st_nxt[ch] != ST_COAST);

      // Pins are decoded from next-state values so they line up with the
      // state register and counter in the same cycle.
      case (w_st_nxt[ch])
        ST_BRAKE, ST_BRAKE_DT: begin
          w_in1_nxt[ch] = 1'b1;
          w_in2_nxt[ch] = 1'b1;
        end
        ST_DRIVE: begin
          w_in1_nxt[ch] = ~w_dir_nxt[ch];
          w_in2_nxt[ch] = w_dir_nxt[ch];
          w_pwm_nxt[ch] = (w_cnt_nxt < w_act_nxt[ch]);
        end
        default: ;
      endcase
    end

    // Idle counter is held at 0 through the cycle the last channel returns
    // to COAST, so STBY stays high for a full IDLE_TIMEOUT after the pins
    // go quiet.
    if (!enable) begin
      w_idle_nxt = c_idle_sat;
    end else if ((|w_nc_cur) || (|w_nc_nxt)) begin
      w_idle_nxt = '0;
    end else if (r_idle < c_idle_sat) begin
      w_idle_nxt = r_idle + IDLE_W'(1);
    end else begin
      w_idle_nxt = r_idle;
    end

    w_stby_nxt  = enable && ((|w_nc_nxt) || (w_idle_nxt < c_idle_sat));
    // Based on next state so no command slips in during the dead-time.
    w_ready_nxt = enable && (w_st_nxt[0] != ST_BRAKE_DT) &&
                  (w_st_nxt[1] != ST_BRAKE_DT);
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir   <= '0;
      r_cnt   <= '0;
      r_idle  <= c_idle_sat;
      r_ready <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_pwm   <= '0;
      r_stby  <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        r_pend[ch] <= '0;
        r_act[ch]  <= '0;
        r_dt[ch]   <= '0;
      end
    end else begin
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
      r_ready <= w_ready_nxt;
      r_in1   <= w_in1_nxt;
      r_in2   <= w_in2_nxt;
      r_pwm   <= w_pwm_nxt;
      r_stby  <= w_stby_nxt;
      for (int ch = 0; ch < 2; ch++) begin
        r_pend[ch] <= w_pend_nxt[ch];
        r_act[ch]  <= w_act_nxt[ch];
        r_dt[ch]   <= w_dt_nxt[ch];
      end
    end
  end

  assign cmd_ready = r_ready;
  assign AIN1      = r_in1[0];
  assign AIN2      = r_in2[0];
  assign PWMA      = r_pwm[0];
  assign BIN1      = r_in1[1];
  assign BIN2      = r_in2[1];
  assign PWMB      = r_pwm[1];
  assign STBY      = r_stby;

endmodule
`default_nettype wire

// File: tb/tb_tb6612_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb6612_pwm_ctrl
//  Purpose  : Directed self-checking bench for tb6612_pwm_ctrl. A bench-side
//             copy of the PWM counter tracks period boundaries; all expected
//             values are hand-computed from the intended behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tb6612_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_chan = 1'b0;
  logic [1:0] cmd_dir = 2'b00;
  logic [7:0] cmd_duty = 8'd0;
  logic       AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;   // bench copy of the PWM counter

  tb6612_pwm_ctrl #(
    .CNT_W       (8),
    .BRAKE_CYC   (16),
    .IDLE_TIMEOUT(1024)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan (cmd_chan),
    .cmd_dir  (cmd_dir),
    .cmd_duty (cmd_duty),
    .AIN1     (AIN1),
    .AIN2     (AIN2),
    .PWMA     (PWMA),
    .BIN1     (BIN1),
    .BIN2     (BIN2),
    .PWMB     (PWMB),
    .STBY     (STBY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      logic en_s;
      en_s = enable & rst_n;
      @(posedge clk);
      if (!en_s)             m_cnt = 0;
      else if (m_cnt == 254) m_cnt = 0;
      else                   m_cnt = m_cnt + 1;
      #1;
    end
  endtask

  task automatic send(input logic ch, input logic [1:0] dir, input logic [7:0] duty);
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_chan  = ch;
    cmd_dir   = dir;
    cmd_duty  = duty;
    step(1);
    cmd_valid = 1'b0;
  endtask

  // Step until the counter is at 0; counts channel-A PWM highs on the way.
  task automatic wait_wrap(output int highs_a);
    highs_a = 0;
    for (int i = 0; i < 300 && m_cnt != 0; i++) begin
      highs_a += int'(PWMA);
      step(1);
    end
  endtask

  task automatic measure(input logic ch, input int periods, output int highs);
    highs = 0;
    for (int i = 0; i < 255 * periods; i++) begin
      highs += ch ? int'(PWMB) : int'(PWMA);
      step(1);
    end
  endtask

  initial begin
    int h;
    int n;
    int rdy_hi;

    // ---- reset state
    #2;
    check("reset_outputs", {cmd_ready, AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("ready_while_disabled", {31'd0, cmd_ready}, 32'd0);
    enable = 1'b1;
    step(1);
    check("enable_ready_stby", {cmd_ready, STBY}, 32'b10);

    // ---- A forward duty 64
    send(1'b0, 2'b01, 8'd64);
    check("a_fwd_pins", {AIN1, AIN2, PWMA, STBY}, 32'b1001);
    wait_wrap(h);
    check("a_pwm_before_wrap", h, 0);
    measure(1'b0, 1, h);
    check("a_duty64", h, 64);

    // ---- A forward 128, then reversal to 200 mid-period
    send(1'b0, 2'b01, 8'd128);
    wait_wrap(h);
    measure(1'b0, 1, h);
    check("a_duty128", h, 128);
    step(100);
    send(1'b0, 2'b10, 8'd200);
    check("a_dt_pins", {AIN1, AIN2, PWMA, cmd_ready}, 32'b1100);
    n = 0;
    rdy_hi = 0;
    while (AIN1 && AIN2 && n < 40) begin
      n++;
      rdy_hi += int'(cmd_ready);
      step(1);
    end
    check("a_dt_length", n, 16);
    check("a_dt_ready_low", rdy_hi, 0);
    check("a_rev_pins", {AIN1, AIN2, PWMA, cmd_ready}, 32'b0101);
    wait_wrap(h);
    measure(1'b0, 1, h);
    check("a_duty200_rev", h, 200);

    // ---- A forward 100, duty 30 requested at cnt 50
    send(1'b0, 2'b01, 8'd100);
    check("a_dt2_pins", {AIN1, AIN2}, 32'b11);
    for (int i = 0; i < 40 && !cmd_ready; i++) step(1);
    check("a_dt2_done", {AIN1, AIN2, cmd_ready}, 32'b101);
    wait_wrap(h);
    h = 0;
    for (int i = 0; i < 255; i++) begin
      h += int'(PWMA);
      if (m_cnt == 50) begin
        cmd_valid = 1'b1;
        cmd_chan  = 1'b0;
        cmd_dir   = 2'b01;
        cmd_duty  = 8'd30;
      end
      step(1);
      cmd_valid = 1'b0;
    end
    check("a_duty100_kept", h, 100);
    measure(1'b0, 1, h);
    check("a_duty30", h, 30);

    // ---- both driving, both coast, STBY timeout
    send(1'b1, 2'b01, 8'd50);
    check("b_fwd_pins", {BIN1, BIN2}, 32'b10);
    send(1'b0, 2'b00, 8'd0);
    send(1'b1, 2'b00, 8'd0);
    check("coast_pins", {AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY}, 32'b0000001);
    n = 0;
    while (STBY && n < 1100) begin
      n++;
      step(1);
    end
    check("stby_hold_cycles", n, 1024);
    check("stby_low", {31'd0, STBY}, 32'd0);

    // ---- B duty edges
    send(1'b1, 2'b01, 8'd0);
    check("b_wake_pins", {BIN1, BIN2, PWMB, STBY}, 32'b1001);
    wait_wrap(h);
    measure(1'b1, 1, h);
    check("b_duty0", h, 0);
    send(1'b1, 2'b01, 8'd255);
    wait_wrap(h);
    measure(1'b1, 3, h);
    check("b_duty255_3per", h, 765);

    // ---- enable dropped during B dead-time
    send(1'b1, 2'b10, 8'd10);
    check("b_dt_pins", {BIN1, BIN2, cmd_ready}, 32'b110);
    step(3);
    enable = 1'b0;
    step(1);
    check("disable_outputs", {cmd_ready, AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY}, 32'd0);
    step(2);
    check("disable_hold", {cmd_ready, AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY}, 32'd0);
    enable = 1'b1;
    step(1);
    check("reenable", {cmd_ready, BIN1, BIN2, STBY}, 32'b1000);
    send(1'b1, 2'b10, 8'd40);
    check("b_rev_from_coast", {BIN1, BIN2, PWMB, STBY}, 32'b0101);
    wait_wrap(h);
    measure(1'b1, 1, h);
    check("b_duty40", h, 40);

    // ---- asynchronous reset mid-period
    send(1'b0, 2'b01, 8'd255);
    wait_wrap(h);
    check("a_full_on", {31'd0, PWMA}, 32'd1);
    step(10);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {cmd_ready, AIN1, AIN2, PWMA, BIN1, BIN2, PWMB, STBY}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_reset", {cmd_ready, AIN1, AIN2, BIN1, BIN2, STBY}, 32'b100000);
    send(1'b0, 2'b10, 8'd20);
    check("a_rev_from_coast", {AIN1, AIN2, PWMA, STBY}, 32'b0101);
    wait_wrap(h);
    measure(1'b0, 1, h);
    check("a_duty20", h, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
